matrix_scan_capture: RTL and testbench
======================================

// Module: matrix_scan_capture
// PURPOSE
//  Receive end of the 16x32 LED-matrix scan interface driven by the game top level
//  (one-hot row strobe plus 32-bit column word, one row per clock).
//  Rebuilds full frames into a ping-pong frame buffer and checks scan legality.
//  Provides a registered random-access row readback for collision logic and the
//  verification scoreboard.
// PARAMETERS
//  ROWS       16  rows per frame; scan_row width
//  COLS       32  columns per row; scan_col and rd_data width
//  ROW_IDX_W  4   log2(ROWS); rd_row width
// PORTS
//  clk          in   1          system clock; all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  scan_en      in   1          sample qualifier; scan_row/scan_col are valid when 1
//  scan_row     in   ROWS       one-hot row strobe; bit i = row i
//  scan_col     in   COLS       lit columns for the strobed row; bit j = column j
//  rd_row       in   ROW_IDX_W  readback row index
//  rd_data      out  COLS       front-bank row rd_row, registered
//  frame_done   out  1          1-cycle pulse when a complete frame becomes front
//  frame_count  out  16         completed frames, wraps 0xFFFF->0
//  locked       out  1          1 while capture is aligned to row 0
//  err_onehot   out  1          sticky: a qualified sample had scan_row zero or multi-hot
//  err_order    out  1          sticky: one-hot row out of sequence
//  clr_err      in   1          clears both sticky error flags
// BEHAVIOUR
//  Reset (rst=1 at an edge): both banks all-zero, front=bank0, state HUNT, rd_data=0,
//   frame_done=0, frame_count=0, locked=0, errors=0, expected row=0. Reset mid-frame
//   discards the partial frame.
//  Only cycles with scan_en=1 are samples. scan_en=0 leaves all state unchanged.
//  Writes go to back bank (~front); the front bank is never written.
//  Row index = bit position of the set bit in scan_row. Legal sequence is 0,1,..,ROWS-1,0.
//  FSM HUNT: a one-hot sample with index 0 writes back[0], sets exp=1, and moves to
//   CAPTURE. Any other one-hot sample is ignored (no error).
//  FSM CAPTURE, one-hot sample with index==exp: write back[exp], then exp++.
//   If exp was ROWS-1: toggle front, pulse frame_done on the next cycle,
//   increment frame_count, set locked=1, and set exp=0. Stay in CAPTURE.
//  CAPTURE, one-hot sample with index!=exp: set err_order, clear locked, and drop the
//   partial frame. If index==0, restart: write back[0], exp=1, stay in CAPTURE.
//   Otherwise go to HUNT.
//  Any state, non-one-hot sample (0 or >=2 bits): set err_onehot, clear locked,
//   go to HUNT, write nothing.
//  Error flags: set has priority over clr_err in the same cycle. A non-one-hot sample
//   sets only err_onehot.
//  Readback: rd_data <= front[rd_row] each clock; latency is 1 cycle.
//   A read issued in the toggle cycle returns the old frame; the next read returns the new one.
//  locked stays 1 across frame boundaries until an error or reset.
// TESTING
//  1 Reset, then 16 rows 0..15 with scan_col=32'h1<<i -> frame_done pulse 1 cycle after
//    row 15; frame_count=1; rd_row=5 gives rd_data=32'h20 one cycle later; locked=1.
//  2 Second frame with all cols=32'hFFFF_FFFF; read row 3 during row-15 cycle gives old 32'h8,
//    next cycle gives 32'hFFFF_FFFF; frame_count=2.
//  3 Mid-frame at exp=7 send row 9 -> err_order=1, locked=0, HUNT; front unchanged;
//    the next full 0..15 sequence completes frame normally.
//  4 scan_row=16'h0003 at exp=4 -> err_onehot=1, err_order=0, no write; clr_err=1
//    in the same cycle as a new error leaves the flag set.
//  5 scan_en toggling 1/0 throughout a frame -> same result as test 1; rst asserted at
//    row 8 -> all outputs 0, and the first frame after reset needs a full 0..15 sequence.
//  6 Force frame_count=16'hFFFF by completing 65535 frames (or in a long sim), complete
//    one more frame -> frame_count=0, frame_done pulses.

Source files
------------

// File: rtl/matrix_scan_capture_if.sv
// Scan-side and readback signals of the LED-matrix capture block.
// scan_en qualifies scan_row/scan_col each cycle; there is no back-pressure, every qualified cycle is consumed.
interface matrix_scan_capture_if #(
   parameter int ROWS      = 16,
   parameter int COLS      = 32,
   parameter int ROW_IDX_W = 4
);
   logic                 scan_en;
   logic [ROWS-1:0]      scan_row;
   logic [COLS-1:0]      scan_col;
   logic [ROW_IDX_W-1:0] rd_row;
   logic                 clr_err;
   logic [COLS-1:0]      rd_data;
   logic                 frame_done;
   logic [15:0]          frame_count;
   logic                 locked;
   logic                 err_onehot;
   logic                 err_order;
   logic                 capturing;

   modport master (
      output scan_en, scan_row, scan_col, rd_row, clr_err,
      input  rd_data, frame_done, frame_count, locked, err_onehot, err_order, capturing
   );

   modport slave (
      input  scan_en, scan_row, scan_col, rd_row, clr_err,
      output rd_data, frame_done, frame_count, locked, err_onehot, err_order, capturing
   );
endinterface

// File: rtl/matrix_scan_capture.sv
// Rebuilds scanned LED-matrix frames into a ping-pong buffer, checks row order and one-hot
// legality, and offers a registered readback of the front (last complete) frame.
module matrix_scan_capture #(
   parameter int ROWS      = 16,
   parameter int COLS      = 32,
   parameter int ROW_IDX_W = 4
) (
   input logic                  clk,
   input logic                  rst,
   matrix_scan_capture_if.slave bus
);
   typedef enum logic {HUNT = 1'b0, CAPTURE = 1'b1} state_t;

   state_t               state;
   logic [COLS-1:0]      mem [2][ROWS];
   logic                 front;
   logic                 back;
   logic [ROW_IDX_W-1:0] exp_row;
   logic                 onehot;
   logic [ROW_IDX_W-1:0] row_idx;

   assign back = ~front;
   assign bus.capturing = (state == CAPTURE);

   always_comb begin
      row_idx = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (bus.scan_row[i]) row_idx = ROW_IDX_W'(i);
      end
   end

   assign onehot = (bus.scan_row != '0) &&
                   ((bus.scan_row & (bus.scan_row - ROWS'(1))) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) mem[b][r] <= '0;
         end
         front           <= 1'b0;
         state           <= HUNT;
         exp_row         <= '0;
         bus.rd_data     <= '0;
         bus.frame_done  <= 1'b0;
         bus.frame_count <= '0;
         bus.locked      <= 1'b0;
         bus.err_onehot  <= 1'b0;
         bus.err_order   <= 1'b0;
      end else begin
         bus.frame_done <= 1'b0;
         // Uses the pre-toggle front, so a read in the toggle cycle still sees the old frame.
         bus.rd_data    <= mem[front][bus.rd_row];
         if (bus.clr_err) begin
            bus.err_onehot <= 1'b0;
            bus.err_order  <= 1'b0;
         end
         if (bus.scan_en) begin
            if (!onehot) begin
               bus.err_onehot <= 1'b1;
               bus.locked     <= 1'b0;
               state          <= HUNT;
               exp_row        <= '0;
            end else if (state == HUNT) begin
               if (row_idx == '0) begin
                  mem[back][row_idx] <= bus.scan_col;
                  exp_row            <= ROW_IDX_W'(1);
                  state              <= CAPTURE;
               end
            end else if (row_idx == exp_row) begin
               mem[back][row_idx] <= bus.scan_col;
               if (exp_row == ROW_IDX_W'(ROWS - 1)) begin
                  front           <= back;
                  bus.frame_done  <= 1'b1;
                  bus.frame_count <= bus.frame_count + 16'd1;
                  bus.locked      <= 1'b1;
                  exp_row         <= '0;
               end else begin
                  exp_row <= exp_row + ROW_IDX_W'(1);
               end
            end else begin
               // Out of order: row 0 doubles as the start of a fresh frame.
               bus.err_order <= 1'b1;
               bus.locked    <= 1'b0;
               if (row_idx == '0) begin
                  mem[back][row_idx] <= bus.scan_col;
                  exp_row            <= ROW_IDX_W'(1);
               end else begin
                  state   <= HUNT;
                  exp_row <= '0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed plus randomized bench for matrix_scan_capture against a frame-level reference model.
module tb_matrix_scan_capture;
   localparam int ROWS      = 16;
   localparam int COLS      = 32;
   localparam int ROW_IDX_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   matrix_scan_capture_if #(.ROWS(ROWS), .COLS(COLS), .ROW_IDX_W(ROW_IDX_W)) bus ();

   matrix_scan_capture #(.ROWS(ROWS), .COLS(COLS), .ROW_IDX_W(ROW_IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: whole frames, next expected row (-1 while hunting).
   logic [COLS-1:0] m_front [ROWS];
   logic [COLS-1:0] m_back  [ROWS];
   int              m_next;
   bit              m_locked, m_eoh, m_eord, m_done;
   logic [15:0]     m_count;
   logic [COLS-1:0] m_rd;
   logic [COLS-1:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void model_reset();
      for (int r = 0; r < ROWS; r++) begin
         m_front[r] = '0;
         m_back[r]  = '0;
      end
      m_next = -1; m_locked = 0; m_eoh = 0; m_eord = 0; m_done = 0;
      m_count = '0; m_rd = '0;
   endfunction

   function automatic void model_step();
      int idx;
      logic [COLS-1:0] tmp [ROWS];
      m_done = 0;
      if (rst) begin
         model_reset();
         return;
      end
      m_rd = m_front[bus.rd_row];
      if (bus.clr_err) begin
         m_eoh  = 0;
         m_eord = 0;
      end
      if (!bus.scan_en) return;
      if ($countones(bus.scan_row) != 1) begin
         m_eoh = 1; m_locked = 0; m_next = -1;
         return;
      end
      idx = 0;
      for (int i = 0; i < ROWS; i++) if (bus.scan_row[i]) idx = i;
      if (m_next < 0) begin
         if (idx == 0) begin
            m_back[0] = bus.scan_col;
            m_next = 1;
         end
      end else if (idx == m_next) begin
         m_back[idx] = bus.scan_col;
         if (idx == ROWS - 1) begin
            tmp = m_front; m_front = m_back; m_back = tmp;
            m_done = 1; m_count++; m_locked = 1; m_next = 0;
         end else begin
            m_next++;
         end
      end else begin
         m_eord = 1; m_locked = 0;
         if (idx == 0) begin
            m_back[0] = bus.scan_col;
            m_next = 1;
         end else begin
            m_next = -1;
         end
      end
   endfunction

   task automatic tick();
      model_step();
      exp_q.push_back(m_rd);
      @(posedge clk);
      #1;
      check("rd_data", bus.rd_data, exp_q.pop_front());
      check("frame_done", 32'(bus.frame_done), 32'(m_done));
      check("frame_count", 32'(bus.frame_count), 32'(m_count));
      check("locked", 32'(bus.locked), 32'(m_locked));
      check("err_onehot", 32'(bus.err_onehot), 32'(m_eoh));
      check("err_order", 32'(bus.err_order), 32'(m_eord));
      check("capturing", 32'(bus.capturing), 32'(m_next >= 0));
   endtask

   task automatic drive(input bit en, input logic [ROWS-1:0] row, input logic [COLS-1:0] col,
                        input logic [ROW_IDX_W-1:0] rd, input bit clr);
      bus.scan_en  = en;
      bus.scan_row = row;
      bus.scan_col = col;
      bus.rd_row   = rd;
      bus.clr_err  = clr;
      tick();
   endtask

   task automatic row_onehot(input int r, input logic [COLS-1:0] col);
      logic [ROWS-1:0] one;
      one = ROWS'(1);
      drive(1'b1, one << r, col, ROW_IDX_W'(5), 1'b0);
   endtask

   initial begin
      logic [COLS-1:0] one_c;
      logic [ROWS-1:0] row;
      one_c = COLS'(1);
      model_reset();
      rst = 1'b1;
      drive(1'b0, '0, '0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b0);
      check("reset_count", 32'(bus.frame_count), 32'd0);
      rst = 1'b0;

      // Frame 1: walking column bit.
      for (int i = 0; i < ROWS; i++) row_onehot(i, one_c << i);
      check("t1_frame_done", 32'(bus.frame_done), 32'd1);
      drive(1'b0, '0, '0, ROW_IDX_W'(5), 1'b0);
      check("t1_rd_row5", bus.rd_data, 32'h20);
      check("t1_count", 32'(bus.frame_count), 32'd1);
      check("t1_locked", 32'(bus.locked), 32'd1);
      check("t1_done_low", 32'(bus.frame_done), 32'd0);

      // Frame 2: all ones, read row 3 during the toggle cycle.
      for (int i = 0; i < ROWS - 1; i++) row_onehot(i, '1);
      drive(1'b1, 16'h8000, '1, ROW_IDX_W'(3), 1'b0);
      check("t2_old_row3", bus.rd_data, 32'h8);
      drive(1'b0, '0, '0, ROW_IDX_W'(3), 1'b0);
      check("t2_new_row3", bus.rd_data, 32'hFFFF_FFFF);
      check("t2_count", 32'(bus.frame_count), 32'd2);

      // Order error at expected row 7.
      for (int i = 0; i < 7; i++) row_onehot(i, 32'h0101_0101 * i);
      row_onehot(9, 32'hDEAD_BEEF);
      check("t3_err_order", 32'(bus.err_order), 32'd1);
      check("t3_locked", 32'(bus.locked), 32'd0);
      check("t3_hunt", 32'(bus.capturing), 32'd0);
      drive(1'b0, '0, '0, ROW_IDX_W'(6), 1'b0);
      check("t3_front_kept", bus.rd_data, 32'hFFFF_FFFF);
      for (int i = 0; i < ROWS; i++) row_onehot(i, 32'h0101_0101 * i);
      check("t3_count", 32'(bus.frame_count), 32'd3);

      // Non-one-hot at expected row 4, clear in the same cycle.
      drive(1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < 4; i++) row_onehot(i, 32'hA5A5_0000);
      drive(1'b1, 16'h0003, 32'h1234_5678, ROW_IDX_W'(1), 1'b1);
      check("t4_err_onehot", 32'(bus.err_onehot), 32'd1);
      check("t4_err_order", 32'(bus.err_order), 32'd0);
      drive(1'b0, '0, '0, ROW_IDX_W'(1), 1'b0);
      check("t4_no_write", bus.rd_data, 32'h0101_0101);

      // scan_en toggling: idle cycles carry garbage that must be ignored.
      drive(1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < ROWS; i++) begin
         row_onehot(i, one_c << i);
         drive(1'b0, ROWS'($urandom), $urandom, ROW_IDX_W'(5), 1'b0);
      end
      drive(1'b0, '0, '0, ROW_IDX_W'(5), 1'b0);
      check("t5_rd_row5", bus.rd_data, 32'h20);

      // Reset at row 8 discards the partial frame.
      for (int i = 0; i < 8; i++) row_onehot(i, 32'hFFFF_0000);
      rst = 1'b1;
      row_onehot(8, 32'hFFFF_0000);
      rst = 1'b0;
      check("t5_rst_count", 32'(bus.frame_count), 32'd0);
      check("t5_rst_rd", bus.rd_data, 32'd0);
      for (int i = 8; i < ROWS; i++) row_onehot(i, 32'h0F0F_0F0F);
      check("t5_no_frame", 32'(bus.frame_count), 32'd0);
      for (int i = 0; i < ROWS; i++) row_onehot(i, 32'h0F0F_0F0F);
      check("t5_first_frame", 32'(bus.frame_count), 32'd1);

      // Randomized frames with sporadic illegal rows, idles and clears.
      for (int f = 0; f < 30; f++) begin
         for (int r = 0; r < ROWS; r++) begin
            row = ROWS'(1) << r;
            if ($urandom_range(0, 24) == 0) row = ROWS'($urandom);
            drive(1'b1, row, $urandom, ROW_IDX_W'($urandom), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
               drive(1'b0, ROWS'($urandom), $urandom, ROW_IDX_W'($urandom), 1'b0);
         end
      end
      for (int r = 0; r < ROWS; r++) drive(1'b0, '0, '0, ROW_IDX_W'(r), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
